mem_port_arbiter: RTL

Shares the single main-memory port between the cache controller's read-miss refill path and its write-through path. Each side raises a request and holds it until a one-cycle completion pulse. The arbiter grants one transaction at a time with round-robin fairness, resolves read-after-write address hazards, and drives a req/ack memory handshake. A watchdog aborts transactions that memory never acknowledges.

---
 rtl/cache_mem_pkg.sv | 23 ++
 rtl/arb_watchdog.sv | 30 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and defaults for the cache controller's main-memory port arbiter.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_t;

    localparam int DEFAULT_TIMEOUT = 64;

    // Round-robin helper: the side that did not win last time.
    function automatic grant_t other_side(input grant_t g);
        return (g == GNT_RD) ? GNT_WR : GNT_RD;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Cycle counter that flags a memory transaction which has gone unacknowledged for too long.
module arb_watchdog
    import cache_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    // Saturates at LAST; the arbiter leaves WAIT on that same cycle, so no wrap is possible.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between refill reads and write-through,
// with read-after-write hazard ordering and a watchdog abort for unacknowledged accesses.
module mem_port_arbiter
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              busy
);

    arb_state_t state_reg;
    arb_state_t state_next;
    grant_t     grant_reg;
    grant_t     last_grant_reg;
    grant_t     gnt_sel;

    logic any_req;
    logic hazard;
    logic in_flight;
    logic abort;
    logic finish;
    logic wd_clr;
    logic wd_en;
    logic wd_expired;

    assign any_req   = rd_req || wr_req;
    assign hazard    = (rd_addr == wr_addr);
    assign in_flight = (state_reg == ISSUE) || (state_reg == WAIT);

    // The first memory cycle can never expire because the counter starts at zero there.
    assign abort  = (state_reg == WAIT) && !mem_ack && wd_expired;
    assign finish = in_flight && (mem_ack || abort);

    assign wd_en  = in_flight;
    assign wd_clr = !in_flight;

    // A refill hitting the pending write's address must wait so it reads the new data.
    always_comb begin
        gnt_sel = GNT_RD;
        if (rd_req && !wr_req) begin
            gnt_sel = GNT_RD;
        end else if (wr_req && !rd_req) begin
            gnt_sel = GNT_WR;
        end else if (hazard) begin
            gnt_sel = GNT_WR;
        end else begin
            gnt_sel = other_side(last_grant_reg);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = mem_ack ? DONE : WAIT;
            WAIT:    if (mem_ack || abort) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= GNT_RD;
            last_grant_reg <= GNT_WR;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
            wr_done        <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            err            <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy      <= (state_next != IDLE);
            rd_valid  <= 1'b0;
            wr_done   <= 1'b0;
            err       <= 1'b0;

            if ((state_reg == IDLE) && any_req) begin
                grant_reg      <= gnt_sel;
                last_grant_reg <= gnt_sel;
                mem_req        <= 1'b1;
                mem_we         <= (gnt_sel == GNT_WR);
                mem_addr       <= (gnt_sel == GNT_WR) ? wr_addr : rd_addr;
                if (gnt_sel == GNT_WR) begin
                    mem_wdata <= wr_data;
                end
            end

            // Completion pulses land on the DONE cycle; rd_data otherwise holds.
            if (finish) begin
                mem_req <= 1'b0;
                err     <= abort;
                if (grant_reg == GNT_RD) begin
                    rd_valid <= 1'b1;
                    rd_data  <= abort ? '0 : mem_rdata;
                end else begin
                    wr_done <= 1'b1;
                end
            end
        end
    end

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

endmodule
